spart_tx_sched: RTL and testbench
=================================

// Module: spart_tx_sched
//
// PURPOSE
//  Round-robin scheduler that shares one UART transmitter among NUM_REQ byte requesters.
//  Accepts one byte at a time over a valid/ready handshake and pulses trmt/tx_data into
//  the transmitter. Waits for tx_done before granting again.
//  Owns the transmitter's baud divisor and applies divisor writes only between frames.
//  Sits between SPART bus-side logic and the UART transmit shifter.
//
// PARAMETERS
//  NUM_REQ       4        number of requesters (2..8)
//  BAUD_W        16       baud divisor width
//  BAUD_DEFAULT  16'd433  divisor after reset (bit period = divisor+1 clks; 50MHz/115200)
//
// PORTS
//  clk          in   1              system clock, all logic on posedge
//  rst          in   1              synchronous, active-high reset
//  req_valid    in   NUM_REQ        requester i has a byte; held until accepted
//  req_data     in   NUM_REQ*8      byte for requester i at [8i+7:8i]
//  req_ready    out  NUM_REQ        one-hot accept strobe; byte taken when valid&ready
//  baud_wr      in   1              write strobe for baud divisor
//  baud_wdata   in   BAUD_W         new divisor value
//  baud_rate    out  BAUD_W         divisor driven to transmitter (registered)
//  baud_pending out  1              write accepted but not yet applied
//  trmt         out  1              one-cycle start pulse to transmitter
//  tx_data      out  8              byte to transmitter (registered, stable from ISSUE to IDLE)
//  tx_done      in   1              transmitter frame-complete level
//  busy         out  1              high in any state other than IDLE
//  grant_id     out  $clog2(NUM_REQ) index of last granted requester
//
// BEHAVIOUR
//  Reset:
//   - State IDLE. req_ready=0, trmt=0, tx_data=0, busy=0, baud_pending=0.
//   - baud_rate=BAUD_DEFAULT, grant_id=NUM_REQ-1, so requester 0 wins first.
//  FSM states: IDLE -> ISSUE -> LAUNCH -> BUSY -> IDLE.
//   IDLE:
//    - If baud_pending: baud_rate<=pending value, clear pending, no grant this cycle.
//    - Else if any req_valid: g = first valid index searching grant_id+1 upward, mod NUM_REQ.
//      req_ready[g]=1 combinationally this cycle; tx_data<=req_data[g]; grant_id<=g; ->ISSUE.
//   ISSUE:  trmt=1 for exactly this cycle; ->LAUNCH.
//   LAUNCH: tx_done ignored (stale level from previous frame); ->BUSY.
//   BUSY:   wait for tx_done==1; then ->IDLE.
//  Latency and throughput:
//   - Accept cycle t; trmt at t+1.
//   - Earliest next accept is the cycle after the IDLE return.
//   - Never two bytes in flight.
//  req_ready: at most one bit set, only in IDLE, only to a requester with valid=1.
//  Baud writes:
//   - baud_wr in any state latches baud_wdata into the pending register and sets baud_pending.
//   - A later write before apply overwrites it (last wins).
//   - Apply happens only in IDLE; baud_rate never changes from ISSUE through BUSY.
//   - baud_wr in IDLE sets pending at the next edge; the next IDLE cycle applies it and
//     delays any grant by 1 cycle.
//  Fairness:
//   - A continuously valid requester is served within NUM_REQ grants.
//   - Only one requester valid: it is granted every frame.
//  tx_done high while IDLE is ignored.
//  busy = (state != IDLE).
//  rst mid-frame:
//   - Immediate return to reset values; the in-flight byte is dropped, no req_ready is issued.
//   - The transmitter is reset from the same source.
//
// TESTING
//  1. Reset, req_valid=4'b0001, data0=8'hA5 -> req_ready=0001 one cycle; trmt next cycle;
//     tx_data=A5 held until IDLE; busy high.
//  2. req_valid=4'b1111 held, 8 frames -> grant order 0,1,2,3,0,1,2,3; one trmt per frame.
//  3. grant_id=1, req_valid=4'b1001 -> next grant 3, then 0.
//  4. baud_wr=16'd26 during BUSY -> baud_pending=1, baud_rate unchanged until IDLE.
//     Then baud_rate=26, pending=0, grant one cycle later.
//  5. Two baud_wr (100, then 200) in one frame -> baud_rate becomes 200 only.
//  6. rst asserted in BUSY -> next cycle IDLE, busy=0, trmt=0, baud_rate=433, grant_id=3;
//     first post-reset grant goes to 0.

Source files
------------

// File: rtl/spart_tx_sched.sv
// Round-robin scheduler sharing one UART transmitter among NUM_REQ byte requesters.
// Baud divisor writes are held pending and applied only while the transmitter is idle.
module spart_tx_sched #(
    parameter int                NUM_REQ      = 4,
    parameter int                BAUD_W       = 16,
    parameter logic [BAUD_W-1:0] BAUD_DEFAULT = 16'd433,
    localparam int               ID_W         = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [NUM_REQ*8-1:0] req_data,
    output logic [NUM_REQ-1:0]   req_ready,
    input  logic                 baud_wr,
    input  logic [BAUD_W-1:0]    baud_wdata,
    output logic [BAUD_W-1:0]    baud_rate,
    output logic                 baud_pending,
    output logic                 trmt,
    output logic [7:0]           tx_data,
    input  logic                 tx_done,
    output logic                 busy,
    output logic [ID_W-1:0]      grant_id
);

    localparam int SUM_W = ID_W + 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_LAUNCH,
        ST_BUSY
    } state_t;

    state_t            state_reg, state_next;
    logic [ID_W-1:0]   grant_id_reg;
    logic [7:0]        tx_data_reg;
    logic [BAUD_W-1:0] baud_rate_reg;
    logic [BAUD_W-1:0] baud_pend_val_reg;
    logic              baud_pending_reg;

    logic [7:0]        req_bytes [NUM_REQ];
    logic [SUM_W-1:0]  cand_sum  [NUM_REQ];
    logic [ID_W-1:0]   cand_idx  [NUM_REQ];
    logic [NUM_REQ-1:0] cand_valid;
    logic [ID_W-1:0]   grant_idx;
    logic              grant_found;
    logic              accept;
    logic              apply;

    // Candidate gi is the requester gi+1 places after the last grant, wrapped mod NUM_REQ.
    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_cand
            assign req_bytes[gi]  = req_data[8*gi +: 8];
            assign cand_sum[gi]   = {1'b0, grant_id_reg} + SUM_W'(gi + 1);
            assign cand_idx[gi]   = (cand_sum[gi] >= SUM_W'(NUM_REQ))
                                  ? (cand_sum[gi][ID_W-1:0] - ID_W'(NUM_REQ))
                                  : cand_sum[gi][ID_W-1:0];
            assign cand_valid[gi] = req_valid[cand_idx[gi]];
        end
    endgenerate

    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (cand_valid[i]) begin
                grant_found = 1'b1;
                grant_idx   = cand_idx[i];
            end
        end
    end

    always_comb begin
        state_next = state_reg;
        accept     = 1'b0;
        apply      = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (baud_pending_reg) begin
                    apply = 1'b1;
                end else if (grant_found) begin
                    accept     = 1'b1;
                    state_next = ST_ISSUE;
                end
            end
            ST_ISSUE:  state_next = ST_LAUNCH;
            // tx_done may still hold the previous frame's level here.
            ST_LAUNCH: state_next = ST_BUSY;
            ST_BUSY: begin
                if (tx_done) begin
                    state_next = ST_IDLE;
                end
            end
            default:   state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg         <= ST_IDLE;
            grant_id_reg      <= ID_W'(NUM_REQ - 1);
            tx_data_reg       <= '0;
            baud_rate_reg     <= BAUD_DEFAULT;
            baud_pend_val_reg <= '0;
            baud_pending_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (accept) begin
                tx_data_reg  <= req_bytes[grant_idx];
                grant_id_reg <= grant_idx;
            end
            if (apply) begin
                baud_rate_reg <= baud_pend_val_reg;
            end
            // A write arriving on the apply cycle stays pending for the next idle cycle.
            if (baud_wr) begin
                baud_pend_val_reg <= baud_wdata;
                baud_pending_reg  <= 1'b1;
            end else if (apply) begin
                baud_pending_reg  <= 1'b0;
            end
        end
    end

    // Strobes are suppressed while reset is held so nothing is accepted or launched.
    assign req_ready    = (accept && !rst) ? (NUM_REQ'(1) << grant_idx) : '0;
    assign trmt         = (state_reg == ST_ISSUE) && !rst;
    assign busy         = (state_reg != ST_IDLE);
    assign tx_data      = tx_data_reg;
    assign grant_id     = grant_id_reg;
    assign baud_rate    = baud_rate_reg;
    assign baud_pending = baud_pending_reg;

endmodule

// File: tb/tb_spart_tx_sched.sv
// Randomized bench for spart_tx_sched against a transaction-level scheduler model.
// Requesters, baud writes, resets and a simple transmitter are driven with $urandom.
module tb_spart_tx_sched;

    localparam int          N    = 4;
    localparam int          BW   = 16;
    localparam logic [15:0] BD   = 16'd433;
    localparam int          IDW  = 2;
    localparam int          CYCLES = 20000;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   req_valid;
    logic [N*8-1:0] req_data;
    logic [N-1:0]   req_ready;
    logic           baud_wr;
    logic [BW-1:0]  baud_wdata;
    logic [BW-1:0]  baud_rate;
    logic           baud_pending;
    logic           trmt;
    logic [7:0]     tx_data;
    logic           tx_done;
    logic           busy;
    logic [IDW-1:0] grant_id;

    spart_tx_sched #(.NUM_REQ(N), .BAUD_W(BW), .BAUD_DEFAULT(BD)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_data     (req_data),
        .req_ready    (req_ready),
        .baud_wr      (baud_wr),
        .baud_wdata   (baud_wdata),
        .baud_rate    (baud_rate),
        .baud_pending (baud_pending),
        .trmt         (trmt),
        .tx_data      (tx_data),
        .tx_done      (tx_done),
        .busy         (busy),
        .grant_id     (grant_id)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Model: channel free flag, cycles since accept, last grant, baud registers, held byte.
    bit          m_free;
    int          m_since;
    int          m_last;
    logic [15:0] m_baud;
    logic [15:0] m_pval;
    bit          m_pend;
    logic [7:0]  m_tx;

    function automatic int next_grant(input logic [N-1:0] v, input int last);
        for (int k = 1; k <= N; k++) begin
            if (v[(last + k) % N]) return (last + k) % N;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_free  = 1'b1;
        m_since = 0;
        m_last  = N - 1;
        m_baud  = BD;
        m_pval  = '0;
        m_pend  = 1'b0;
        m_tx    = 8'h00;
    endtask

    logic [N-1:0] acc_mask;
    logic [N-1:0] allow_mask;
    bit           trmt_seen;
    bit           rst_seen;
    int           tx_cnt;

    initial begin
        logic [N-1:0] exp_ready;
        logic         exp_trmt;
        int           g;
        bit           apply;

        rst        = 1'b1;
        req_valid  = '0;
        req_data   = '0;
        baud_wr    = 1'b0;
        baud_wdata = '0;
        tx_done    = 1'b1;
        tx_cnt     = 0;
        acc_mask   = '0;
        allow_mask = '1;
        trmt_seen  = 1'b0;
        rst_seen   = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        for (int cyc = 0; cyc < CYCLES; cyc++) begin
            @(negedge clk);
            exp_ready = '0;
            exp_trmt  = 1'b0;
            g         = -1;
            if (!rst && m_free && !m_pend) begin
                g = next_grant(req_valid, m_last);
                if (g >= 0) exp_ready[g] = 1'b1;
            end
            if (!rst && !m_free && m_since == 1) exp_trmt = 1'b1;

            chk("req_ready",    32'(req_ready),    32'(exp_ready));
            chk("trmt",         32'(trmt),         32'(exp_trmt));
            chk("busy",         32'(busy),         32'(!m_free));
            chk("tx_data",      32'(tx_data),      32'(m_tx));
            chk("baud_rate",    32'(baud_rate),    32'(m_baud));
            chk("baud_pending", 32'(baud_pending), 32'(m_pend));
            chk("grant_id",     32'(grant_id),     32'(m_last));

            trmt_seen = trmt;
            rst_seen  = rst;
            acc_mask  = '0;
            if (rst) begin
                model_reset();
            end else begin
                apply = m_free && m_pend;
                if (m_free) begin
                    if (apply) begin
                        m_baud = m_pval;
                    end else if (g >= 0) begin
                        m_tx        = req_data[8*g +: 8];
                        m_last      = g;
                        m_free      = 1'b0;
                        m_since     = 1;
                        acc_mask[g] = 1'b1;
                    end
                end else if (m_since >= 3 && tx_done) begin
                    m_free = 1'b1;
                end else begin
                    m_since++;
                end
                if (baud_wr) begin
                    m_pend = 1'b1;
                    m_pval = baud_wdata;
                end else if (apply) begin
                    m_pend = 1'b0;
                end
            end
            if (acc_mask != '0) begin
                $display("cyc %0d: grant %0d byte %02h baud %0d", cyc, m_last, m_tx, m_baud);
            end

            @(posedge clk);
            #1;
            // Phases alternate between all requesters, a single one, and random subsets.
            if (cyc % 1500 == 0) begin
                case ((cyc / 1500) % 3)
                    0:       allow_mask = '1;
                    1:       allow_mask = N'(1) << $urandom_range(N - 1);
                    default: allow_mask = N'($urandom_range(15, 1));
                endcase
            end
            for (int i = 0; i < N; i++) begin
                if (acc_mask[i]) req_valid[i] = 1'b0;
                if (!req_valid[i] && allow_mask[i] && ($urandom % 3 == 0)) begin
                    req_valid[i]        = 1'b1;
                    req_data[8*i +: 8]  = 8'($urandom);
                end
            end
            baud_wr    = ($urandom % 20 == 0);
            baud_wdata = 16'($urandom);
            // Transmitter: tx_done keeps its stale level for one cycle after trmt.
            if (rst_seen) begin
                tx_cnt  = 0;
                tx_done = 1'b1;
            end else if (trmt_seen) begin
                tx_cnt = 2 + $urandom_range(5);
            end else begin
                if (tx_cnt > 0) tx_cnt--;
                tx_done = (tx_cnt == 0);
            end
            rst = ($urandom % 500 == 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
        $finish;
    end

endmodule
